// File: rtl/imul_arb_pkg.sv
// -----------------------------------------------------------------------------
// imul_arb_pkg
//   Shared defaults and types for the shared-multiplier arbiter.
//   - IMUL_N / IMUL_NREQ : default operand width and requester count
//   - idw()              : requester-id width, never narrower than one bit
//   - imul_req_t         : one accepted operation {a, b, id} at default widths
//   - imul_resp_t        : one product {prod, id} at default widths
// -----------------------------------------------------------------------------
package imul_arb_pkg;

    localparam int IMUL_N    = 24;
    localparam int IMUL_NREQ = 2;

    // A single requester still needs a one-bit id field so ports never vanish.
    function automatic int idw(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    localparam int IMUL_IDW = idw(IMUL_NREQ);

    typedef struct packed {
        logic [IMUL_N-1:0]   a;
        logic [IMUL_N-1:0]   b;
        logic [IMUL_IDW-1:0] id;
    } imul_req_t;

    typedef struct packed {
        logic [2*IMUL_N-1:0] prod;
        logic [IMUL_IDW-1:0] id;
    } imul_resp_t;

endpackage

// File: rtl/imul_arb_if.sv
// -----------------------------------------------------------------------------
// imul_arb_if
//   Request/response bundle between the requesters plus consumer (master) and
//   the shared multiplier arbiter (slave).
//   req_valid/req_ready : per-requester handshake, operands packed i*N +: N
//   req_a/req_b         : packed operands
//   resp_valid/ready    : single in-order response channel
//   resp_out/resp_id    : exact 2N-bit product and issuing requester
//   busy/op_count       : pipeline occupancy and saturating accept counter
// -----------------------------------------------------------------------------
interface imul_arb_if
    import imul_arb_pkg::*;
#(
    parameter int N    = IMUL_N,
    parameter int NREQ = IMUL_NREQ
);
    localparam int IDW = idw(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [2*N-1:0]    resp_out;
    logic [IDW-1:0]    resp_id;
    logic              busy;
    logic [31:0]       op_count;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_out, resp_id, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_out, resp_id, busy, op_count
    );

endinterface

// File: rtl/imul.sv
// -----------------------------------------------------------------------------
// imul
//   Combinational unsigned N x N -> 2N multiplier.
//   a, b : operands
//   out  : exact product
// -----------------------------------------------------------------------------
module imul #(
    parameter int N = 24
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] out
);
    // Widen before multiplying so the full 2N-bit product is kept.
    assign out = {{N{1'b0}}, a} * {{N{1'b0}}, b};

endmodule

// File: rtl/imul_arb_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
//   Combinational round-robin picker.
//   i_req   : request vector
//   i_ptr   : highest-priority index for this scan
//   i_en    : grant allowed this cycle
//   o_grant : one-hot grant (zero when disabled or nothing requested)
//   o_idx   : index of the granted requester
//   o_valid : a grant was issued
// -----------------------------------------------------------------------------
module rr_arb
    import imul_arb_pkg::*;
#(
    parameter  int NREQ = IMUL_NREQ,
    localparam int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_en,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_valid
);
    logic [IDW-1:0] w_cand;

    // NOTE: every output gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        // Scan ptr, ptr+1, ... wrapping at NREQ; first valid requester wins.
        for (int k = 0; k < NREQ; k++) begin
            w_cand = IDW'((int'(i_ptr) + k) % NREQ);
            if (i_en && !o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imul_arb.sv
// -----------------------------------------------------------------------------
// imul_arb
//   Shares one combinational multiplier between NREQ requesters.
//   Round-robin grant -> S1 operand register -> imul -> S2 result register.
//   One op per cycle, responses in accept order, tagged with requester id.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, drops all in-flight ops
//   bus : imul_arb_if slave port (request handshakes, response channel,
//         busy, op_count)
// -----------------------------------------------------------------------------
module imul_arb
    import imul_arb_pkg::*;
#(
    parameter int N    = IMUL_N,
    parameter int NREQ = IMUL_NREQ
) (
    input  logic      clk,
    input  logic      rst,
    imul_arb_if.slave bus
);
    localparam int IDW = idw(NREQ);

    typedef struct packed {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [IDW-1:0] id;
    } s1_t;

    typedef struct packed {
        logic [2*N-1:0] prod;
        logic [IDW-1:0] id;
    } s2_t;

    logic           r_s1_valid;
    s1_t            r_s1;
    logic           r_resp_valid;
    s2_t            r_resp;
    logic [IDW-1:0] r_rr_ptr;
    logic [31:0]    r_op_count;

    logic            w_s2_adv;
    logic            w_s1_adv;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_accept;
    logic [IDW-1:0]  w_ptr_next;
    logic [N-1:0]    w_sel_a;
    logic [N-1:0]    w_sel_b;
    logic [2*N-1:0]  w_prod;

    // S2 can take a value when empty or being drained; S1 likewise when
    // empty or moving into S2. This lets the pipeline slide at full rate.
    assign w_s2_adv = !r_resp_valid || bus.resp_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    rr_arb #(
        .NREQ (NREQ)
    ) u_rr_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .i_en    (w_s1_adv && !rst),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_accept)
    );

    // A grant is only ever issued to a valid requester, so a grant is a handshake.
    assign bus.req_ready = w_grant;

    assign w_ptr_next = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == IDW'(i)) begin
                w_sel_a = bus.req_a[i*N +: N];
                w_sel_b = bus.req_b[i*N +: N];
            end
        end
    end

    imul #(
        .N (N)
    ) u_imul (
        .a   (r_s1.a),
        .b   (r_s1.b),
        .out (w_prod)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp       <= '0;
            r_rr_ptr     <= '0;
            r_op_count   <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= w_accept;
            end
            if (w_accept) begin
                r_rr_ptr <= w_ptr_next;
                if (r_op_count != 32'hFFFF_FFFF) begin
                    r_op_count <= r_op_count + 32'd1;
                end
            end
            if (w_s2_adv) begin
                r_resp_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_resp <= '{prod: w_prod, id: r_s1.id};
                end
            end
        end
    end

    // NOTE: the S1 payload has no reset; it is qualified by r_s1_valid and is
    // only loaded on a handshake, which reset already suppresses.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1 <= '{a: w_sel_a, b: w_sel_b, id: w_idx};
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_out   = r_resp.prod;
    assign bus.resp_id    = r_resp.id;
    assign bus.busy       = r_s1_valid || r_resp_valid;
    assign bus.op_count   = r_op_count;

endmodule
